// File: rtl/axi_stream_downsizer_pkg.sv
// ---------------------------------------------------------------------------
// axi_stream_downsizer_pkg
//
// Shared definitions for the AXI-Stream width converters (downsizer today,
// upsizer successor later).
//
// Contents:
//   dsState_e    : two-state drain FSM encoding (EMPTY / DRAIN)
//   clog2()      : constant-foldable ceil(log2()) used for index widths
//   laneKeepW()  : number of tkeep bits that cover one narrow lane
// ---------------------------------------------------------------------------
package axi_stream_downsizer_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } dsState_e;

    // ceil(log2(value)); returns at least 1 so an index bus is never zero-width.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

    // tkeep bits per lane of the given data width (one bit per byte).
    function automatic int laneKeepW(input int dataWidth);
        return dataWidth / 8;
    endfunction

endpackage

// File: rtl/axi_stream_downsizer_keep_scan.sv
// ---------------------------------------------------------------------------
// axi_keep_scan
//
// Purely combinational analysis of a wide tkeep vector split into lanes.
//
// Ports:
//   keep         in   LANES*LANE_KEEP_W  wide byte enables
//   highLane     out  IDX_W              index of highest populated lane
//   anyPopulated out  1                  at least one keep bit is set
//   sparse       out  1                  an empty lane lies below highLane
//
// A lane is "populated" when any of its keep bits is set. With no populated
// lane at all, highLane reads 0 and sparse reads 0.
// ---------------------------------------------------------------------------
module axi_keep_scan
    import axi_stream_downsizer_pkg::*;
#(
    parameter int LANES       = 2,
    parameter int LANE_KEEP_W = 4,
    localparam int IDX_W      = clog2(LANES)
) (
    input  logic [LANES*LANE_KEEP_W-1:0] keep,
    output logic [IDX_W-1:0]             highLane,
    output logic                         anyPopulated,
    output logic                         sparse
);

    logic [LANES-1:0] populated;

    always_comb begin
        populated = '0;
        for (int i = 0; i < LANES; i++) begin
            populated[i] = |keep[i*LANE_KEEP_W +: LANE_KEEP_W];
        end
    end

    assign anyPopulated = |populated;

    // Ascending scan: the last populated lane seen wins.
    always_comb begin
        highLane = '0;
        for (int i = 0; i < LANES; i++) begin
            if (populated[i]) begin
                highLane = IDX_W'(i);
            end
        end
    end

    // A hole is only an error when a populated lane sits above it.
    always_comb begin
        sparse = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (!populated[i] && (IDX_W'(i) < highLane)) begin
                sparse = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_stream_downsizer.sv
// ---------------------------------------------------------------------------
// axi_stream_downsizer
//
// Single-clock AXI-Stream width down-converter. Each accepted wide beat is
// held in one register stage and emitted as narrow lanes 0..h (LSB lane
// first), where h is the highest lane with any keep bit set.
//
// Ports:
//   sysClk            in   1               sole clock, rising edge
//   reset             in   1               asynchronous, active-high
//   sAxiStreamTdata   in   S_DATA_WIDTH    wide data
//   sAxiStreamTkeep   in   S_DATA_WIDTH/8  wide byte enables
//   sAxiStreamTuser   in   USER_WIDTH      per-beat sideband
//   sAxiStreamTlast   in   1               end of packet
//   sAxiStreamTvalid  in   1               wide beat valid
//   sAxiStreamTready  out  1               wide beat accepted
//   mAxiStreamTdata   out  M_DATA_WIDTH    narrow data
//   mAxiStreamTkeep   out  M_DATA_WIDTH/8  narrow byte enables
//   mAxiStreamTuser   out  USER_WIDTH      sideband of the current wide beat
//   mAxiStreamTlast   out  1               end of packet (lane h only)
//   mAxiStreamTvalid  out  1               narrow beat valid
//   mAxiStreamTready  in   1               downstream ready
//   keepErr           out  1               pulse: sparse keep on accepted beat
//   nullDrop          out  1               pulse: all-zero-keep beat dropped
//
// All m* outputs are driven only from the holding registers, so there is no
// combinational s* -> m* path. sAxiStreamTready looks at mAxiStreamTready so
// the last lane's handshake can reload the next beat in the same cycle.
// ---------------------------------------------------------------------------
module axi_stream_downsizer
    import axi_stream_downsizer_pkg::*;
#(
    parameter int M_DATA_WIDTH = 32,
    parameter int RATIO        = 2,
    parameter int USER_WIDTH   = 8
) (
    input  logic                                 sysClk,
    input  logic                                 reset,

    input  logic [M_DATA_WIDTH*RATIO-1:0]        sAxiStreamTdata,
    input  logic [laneKeepW(M_DATA_WIDTH)*RATIO-1:0] sAxiStreamTkeep,
    input  logic [USER_WIDTH-1:0]                sAxiStreamTuser,
    input  logic                                 sAxiStreamTlast,
    input  logic                                 sAxiStreamTvalid,
    output logic                                 sAxiStreamTready,

    output logic [M_DATA_WIDTH-1:0]              mAxiStreamTdata,
    output logic [laneKeepW(M_DATA_WIDTH)-1:0]   mAxiStreamTkeep,
    output logic [USER_WIDTH-1:0]                mAxiStreamTuser,
    output logic                                 mAxiStreamTlast,
    output logic                                 mAxiStreamTvalid,
    input  logic                                 mAxiStreamTready,

    output logic                                 keepErr,
    output logic                                 nullDrop
);

    localparam int S_DATA_WIDTH = M_DATA_WIDTH * RATIO;
    localparam int M_KEEP_W     = laneKeepW(M_DATA_WIDTH);
    localparam int S_KEEP_W     = M_KEEP_W * RATIO;
    localparam int IDX_W        = clog2(RATIO);

    dsState_e                state;
    logic [IDX_W-1:0]        laneIdx;
    logic [IDX_W-1:0]        hLane_p1;
    logic [S_DATA_WIDTH-1:0] holdData_p1;
    logic [S_KEEP_W-1:0]     holdKeep_p1;
    logic [USER_WIDTH-1:0]   holdUser_p1;
    logic                    holdLast_p1;

    logic [IDX_W-1:0]        scanHigh;
    logic                    scanAny;
    logic                    scanSparse;

    logic                    atLastLane;
    logic                    sAccept;
    logic                    mHandshake;

    axi_keep_scan #(
        .LANES       (RATIO),
        .LANE_KEEP_W (M_KEEP_W)
    ) keepScan (
        .keep         (sAxiStreamTkeep),
        .highLane     (scanHigh),
        .anyPopulated (scanAny),
        .sparse       (scanSparse)
    );

    assign atLastLane = (laneIdx == hLane_p1);

    // Ready when empty, or when the final lane is leaving this very cycle.
    // Held low throughout reset so nothing is accepted while it is asserted.
    assign sAxiStreamTready = !reset &&
                              ((state == EMPTY) ||
                               (atLastLane && mAxiStreamTready));

    assign sAccept    = sAxiStreamTvalid && sAxiStreamTready;
    assign mHandshake = mAxiStreamTvalid && mAxiStreamTready;

    // ---- stage p0 -> p1: capture the wide beat and walk its lanes ----
    always_ff @(posedge sysClk or posedge reset) begin
        if (reset) begin
            state       <= EMPTY;
            laneIdx     <= '0;
            hLane_p1    <= '0;
            holdData_p1 <= '0;
            holdKeep_p1 <= '0;
            holdUser_p1 <= '0;
            holdLast_p1 <= 1'b0;
            keepErr     <= 1'b0;
            nullDrop    <= 1'b0;
        end else begin
            keepErr  <= 1'b0;
            nullDrop <= 1'b0;
            case (state)
                EMPTY: begin
                    if (sAccept) begin
                        if (scanAny) begin
                            holdData_p1 <= sAxiStreamTdata;
                            holdKeep_p1 <= sAxiStreamTkeep;
                            holdUser_p1 <= sAxiStreamTuser;
                            holdLast_p1 <= sAxiStreamTlast;
                            hLane_p1    <= scanHigh;
                            laneIdx     <= '0;
                            keepErr     <= scanSparse;
                            state       <= DRAIN;
                        end else begin
                            // Null beat: swallowed, including any tlast it carried.
                            nullDrop <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!atLastLane) begin
                        if (mHandshake) begin
                            laneIdx <= laneIdx + IDX_W'(1);
                        end
                    end else if (sAccept) begin
                        // sAccept here implies the last lane handshakes too.
                        if (scanAny) begin
                            holdData_p1 <= sAxiStreamTdata;
                            holdKeep_p1 <= sAxiStreamTkeep;
                            holdUser_p1 <= sAxiStreamTuser;
                            holdLast_p1 <= sAxiStreamTlast;
                            hLane_p1    <= scanHigh;
                            laneIdx     <= '0;
                            keepErr     <= scanSparse;
                        end else begin
                            nullDrop <= 1'b1;
                            state    <= EMPTY;
                        end
                    end else if (mHandshake) begin
                        state <= EMPTY;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

    // ---- stage p1 -> output: lane select from the holding register ----
    always_comb begin
        mAxiStreamTdata = '0;
        mAxiStreamTkeep = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (laneIdx == IDX_W'(i)) begin
                mAxiStreamTdata = holdData_p1[i*M_DATA_WIDTH +: M_DATA_WIDTH];
                mAxiStreamTkeep = holdKeep_p1[i*M_KEEP_W +: M_KEEP_W];
            end
        end
    end

    assign mAxiStreamTvalid = (state == DRAIN);
    assign mAxiStreamTuser  = holdUser_p1;
    assign mAxiStreamTlast  = holdLast_p1 && atLastLane;

endmodule
